// File: rtl/muldiv_pkg.sv
// Shared constants and enumerations for the iterative multiply/divide unit.
// Opcode values match the encoding driven on the op bus by the controller.
package muldiv_pkg;

   localparam int unsigned MULDIV_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring divide step, both working on unsigned magnitudes.
module muldiv_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_mode_div,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_shreg,
   input  logic [WIDTH-1:0] i_operand,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_shreg
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_shifted;
   logic [WIDTH-1:0] w_diff;
   logic             w_ge;

   // Multiply: {acc,shreg} is the running product; shreg[0] is the next multiplier bit.
   assign w_sum     = {1'b0, i_acc} + {1'b0, i_operand};
   assign w_add     = i_shreg[0] ? w_sum : {1'b0, i_acc};

   // Divide: acc is the partial remainder, shreg shifts the dividend out and quotient in.
   assign w_shifted = {i_acc, i_shreg[WIDTH-1]};
   assign w_ge      = (w_shifted >= {1'b0, i_operand});
   assign w_diff    = w_shifted[WIDTH-1:0] - i_operand;

   always_comb begin
      o_acc   = w_add[WIDTH:1];
      o_shreg = {w_add[0], i_shreg[WIDTH-1:1]};
      if (i_mode_div) begin
         o_acc   = w_ge ? w_diff : w_shifted[WIDTH-1:0];
         o_shreg = {i_shreg[WIDTH-2:0], w_ge};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: WIDTH unsigned iterations on
// operand magnitudes, then one fix-up cycle applying signs and writing HI/LO.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             r_state,   w_state_next;
   logic [CNT_W-1:0]   r_cnt,     w_cnt_next;
   logic [WIDTH-1:0]   r_acc,     w_acc_next;
   logic [WIDTH-1:0]   r_shreg,   w_shreg_next;
   logic [WIDTH-1:0]   r_operand, w_operand_next;
   logic [WIDTH-1:0]   r_hi,      w_hi_next;
   logic [WIDTH-1:0]   r_lo,      w_lo_next;
   logic               r_is_div,  w_is_div_next;
   logic               r_neg_res, w_neg_res_next;
   logic               r_neg_rem, w_neg_rem_next;
   logic               r_dz,      w_dz_next;
   logic               r_busy,    w_busy_next;
   logic               r_done,    w_done_next;

   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH-1:0]   w_step_acc;
   logic [WIDTH-1:0]   w_step_shreg;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_neg;
   logic [WIDTH-1:0]   w_quot_neg;
   logic [WIDTH-1:0]   w_rem_neg;

   // Only MULT/DIV (op[0]=0, op[2]=0) treat operands as two's complement.
   assign w_signed = ~op[0] & ~op[2];
   assign w_a_neg  = w_signed & a[WIDTH-1];
   assign w_b_neg  = w_signed & b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
   assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

   assign w_prod     = {r_acc, r_shreg};
   assign w_prod_neg = ~w_prod + 1'b1;
   assign w_quot_neg = ~r_shreg + 1'b1;
   assign w_rem_neg  = ~r_acc + 1'b1;

   muldiv_step #(
      .WIDTH      (WIDTH)
   ) u_step (
      .i_mode_div (r_is_div),
      .i_acc      (r_acc),
      .i_shreg    (r_shreg),
      .i_operand  (r_operand),
      .o_acc      (w_step_acc),
      .o_shreg    (w_step_shreg)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_shreg   <= '0;
         r_operand <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dz      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_acc     <= w_acc_next;
         r_shreg   <= w_shreg_next;
         r_operand <= w_operand_next;
         r_hi      <= w_hi_next;
         r_lo      <= w_lo_next;
         r_is_div  <= w_is_div_next;
         r_neg_res <= w_neg_res_next;
         r_neg_rem <= w_neg_rem_next;
         r_dz      <= w_dz_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_acc_next     = r_acc;
      w_shreg_next   = r_shreg;
      w_operand_next = r_operand;
      w_hi_next      = r_hi;
      w_lo_next      = r_lo;
      w_is_div_next  = r_is_div;
      w_neg_res_next = r_neg_res;
      w_neg_rem_next = r_neg_rem;
      w_dz_next      = r_dz;
      w_done_next    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MTHI: w_hi_next = a;
                  OP_MTLO: w_lo_next = a;
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     w_is_div_next  = op[1];
                     w_neg_res_next = w_a_neg ^ w_b_neg;
                     w_neg_rem_next = w_a_neg;
                     w_dz_next      = (b == '0);
                     w_acc_next     = '0;
                     // Multiply shifts the multiplier out of shreg; divide shifts the dividend.
                     w_shreg_next   = op[1] ? w_a_mag : w_b_mag;
                     w_operand_next = op[1] ? w_b_mag : w_a_mag;
                     w_cnt_next     = '0;
                     w_state_next   = S_CALC;
                  end
                  default: ;
               endcase
            end
         end
         S_CALC: begin
            w_acc_next   = w_step_acc;
            w_shreg_next = w_step_shreg;
            w_cnt_next   = r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_next = S_FIX;
            end
         end
         S_FIX: begin
            if (r_is_div) begin
               // Divide by zero leaves the remainder equal to |a|, which re-signs back to a.
               w_lo_next = r_dz ? '1 : (r_neg_res ? w_quot_neg : r_shreg);
               w_hi_next = r_neg_rem ? w_rem_neg : r_acc;
            end else begin
               {w_hi_next, w_lo_next} = r_neg_res ? w_prod_neg : w_prod;
            end
            w_done_next  = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase

      w_busy_next = (w_state_next != S_IDLE);
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random mult/div
// traffic compared against an arithmetic reference model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          n_checks;
   int          n_errors;
   logic [31:0] model_hi;
   logic [31:0] model_lo;

   muldiv_unit #(
      .WIDTH (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l);
      int          sx;
      int          sy;
      longint      sp;
      logic [63:0] p;
      sx = $signed(x);
      sy = $signed(y);
      h  = model_hi;
      l  = model_lo;
      case (o)
         3'd0: begin
            sp = longint'(sx) * longint'(sy);
            p  = sp;
            h  = p[63:32];
            l  = p[31:0];
         end
         3'd1: begin
            p = {32'd0, x} * {32'd0, y};
            h = p[63:32];
            l = p[31:0];
         end
         3'd2: begin
            if (y == 32'd0) begin
               h = x;
               l = 32'hFFFF_FFFF;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               h = 32'd0;
               l = 32'h8000_0000;
            end else begin
               l = sx / sy;
               h = sx % sy;
            end
         end
         3'd3: begin
            if (y == 32'd0) begin
               h = x;
               l = 32'hFFFF_FFFF;
            end else begin
               l = x / y;
               h = x % y;
            end
         end
         default: ;
      endcase
   endfunction

   // inj_kind: 0 none, 1 start with MTLO while busy, 2 reset while busy (at cycle N+inj_k)
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int inj_k, input int inj_kind);
      logic [31:0] eh;
      logic [31:0] el;
      int          k;
      int          busy_cnt;
      logic        hold_ok;
      logic        aborted;
      logic        late_done;
      ref_model(o, x, y, eh, el);
      @(posedge clk); #1;
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
      k = 1; busy_cnt = 0; hold_ok = 1'b1; aborted = 1'b0;
      while (done !== 1'b1 && k < 100) begin
         if (busy === 1'b1) busy_cnt++;
         if (hi !== model_hi || lo !== model_lo) hold_ok = 1'b0;
         if (inj_kind == 1 && k == inj_k) begin
            start = 1'b1; op = OP_MTLO; a = $urandom;
         end
         if (inj_kind == 2 && k == inj_k) reset = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (inj_kind == 2 && k == inj_k) begin
            reset = 1'b0;
            aborted = 1'b1;
            break;
         end
         k++;
      end
      check("hold_while_busy", 64'(hold_ok), 64'd1);
      if (aborted) begin
         check("abort_busy", 64'(busy), 64'd0);
         check("abort_done", 64'(done), 64'd0);
         check("abort_hi", 64'(hi), 64'd0);
         check("abort_lo", 64'(lo), 64'd0);
         model_hi = 32'd0;
         model_lo = 32'd0;
         late_done = 1'b0;
         for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) late_done = 1'b1;
         end
         check("abort_no_done", 64'(late_done), 64'd0);
         $display("op=%0d a=0x%08h b=0x%08h aborted by reset at N+%0d", o, x, y, inj_k);
      end else begin
         check("latency", 64'(k), 64'd34);
         check("busy_cycles", 64'(busy_cnt), 64'd33);
         check("busy_at_done", 64'(busy), 64'd0);
         check("hi", 64'(hi), 64'(eh));
         check("lo", 64'(lo), 64'(el));
         model_hi = eh;
         model_lo = el;
         $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h", o, x, y, hi, lo);
         @(posedge clk); #1;
         check("done_pulse", 64'(done), 64'd0);
      end
   endtask

   task automatic run_move(input logic [2:0] o, input logic [31:0] x);
      @(posedge clk); #1;
      start = 1'b1; op = o; a = x; b = $urandom;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom;
      if (o == OP_MTHI) model_hi = x;
      if (o == OP_MTLO) model_lo = x;
      check("move_hi", 64'(hi), 64'(model_hi));
      check("move_lo", 64'(lo), 64'(model_lo));
      check("move_busy", 64'(busy), 64'd0);
      check("move_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      check("move_idle", 64'(busy), 64'd0);
      $display("op=%0d a=0x%08h -> hi=0x%08h lo=0x%08h", o, x, hi, lo);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      n_checks = 0;
      n_errors = 0;
      model_hi = 32'd0;
      model_lo = 32'd0;
      reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_hi", 64'(hi), 64'd0);
      check("reset_lo", 64'(lo), 64'd0);
      reset = 1'b0;

      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
      check("multu_max_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
      check("multu_max_lo", 64'(lo), 64'h0000_0000_0000_0001);
      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 0);
      check("mult_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      check("mult_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
      check("div_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
      check("div_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
      run_op(OP_DIVU, 32'd100, 32'd7, 0, 0);
      check("divu_lo", 64'(lo), 64'd14);
      check("divu_hi", 64'(hi), 64'd2);
      run_op(OP_DIVU, 32'h1234, 32'd0, 0, 0);
      check("divu_dz_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
      check("divu_dz_hi", 64'(hi), 64'h1234);
      run_op(OP_DIV, 32'hFFFF_FF00, 32'd0, 0, 0);
      check("div_dz_hi", 64'(hi), 64'h0000_0000_FFFF_FF00);
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      check("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
      check("div_ovf_hi", 64'(hi), 64'd0);

      run_move(OP_MTHI, 32'hDEAD);
      check("mthi_val", 64'(hi), 64'hDEAD);
      run_move(3'b110, 32'h5555_AAAA);
      run_move(3'b111, 32'hAAAA_5555);
      run_op(OP_MULTU, 32'd5, 32'd6, 10, 1);
      check("mtlo_ignored_lo", 64'(lo), 64'd30);
      check("mtlo_ignored_hi", 64'(hi), 64'd0);
      run_move(OP_MTLO, 32'hBEEF);

      run_op(OP_MULTU, 32'd5, 32'd6, 15, 2);

      for (int t = 0; t < 40; t++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: begin ra = 32'($urandom_range(0, 1000)); rb = 32'($urandom_range(1, 50)); end
            3: rb = -32'($urandom_range(1, 50));
            default: ;
         endcase
         run_op(ro, ra, rb, 0, 0);
         if (t % 10 == 5) run_move(3'($urandom_range(4, 7)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Sits beside the ALU on the same operand buses (a, b) and replaces the single-cycle HiLo update.
- Computes the 64-bit product, or the quotient and remainder, over a fixed number of cycles under a start/busy/done handshake.
- The controller stalls on busy and reads hi/lo on MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- a  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
- b  input  WIDTH  multiplier / divisor
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when hi/lo hold a new mult/div result
- hi  output  WIDTH  high product word / remainder
- lo  output  WIDTH  low product word / quotient

Behaviour:
- Reset: synchronous, active-high.
  - State goes to IDLE; hi=0, lo=0, busy=0, done=0; the iteration counter clears.
  - Reset mid-operation aborts the operation with no partial write to hi/lo.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) <= a at that edge. Stay IDLE, busy stays 0, no done pulse.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU:
  - Latch op and the operand magnitudes; for signed ops, latch absolute values plus sign flags.
  - Counter <= 0; go to CALC.
- CALC: one shift-add (multiply) or one restoring-subtract (divide) step per cycle. After WIDTH cycles, go to FIX.
- FIX:
  - Apply sign correction: negate the product if the operand signs differ; negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo; done <= 1 for exactly one cycle; return to IDLE.
- Latency: start high in cycle N → busy in cycles N+1..N+33 → done=1 and new hi/lo visible in cycle N+34. The latency is fixed for every op, including special cases.
- busy is registered and equals (state != IDLE).
- start while busy=1 is ignored; the in-flight operation is unaffected.
- start with op=11x: ignored.
- hi/lo hold their values at all times except on a FIX write, an MTHI/MTLO write, or reset.
- Width rules:
  - MULTU: {hi,lo} = a*b, unsigned, 2*WIDTH bits.
  - MULT: two's-complement product, 2*WIDTH bits.
  - No overflow is possible for either multiply.
- Divide by zero (DIV or DIVU, b=0): lo=all ones, hi=a. Full latency; no exception.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- Operands a/b are don't-care after the start cycle; internal latched copies are used.

Decomposition:
- Package muldiv_pkg holds:
  - WIDTH default constant
  - typedef enum for op codes: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
  - typedef enum for FSM states: S_IDLE, S_CALC, S_FIX
- Sub-module muldiv_step (combinational): one iteration step.
  - Inputs: mode, partial remainder/accumulator, shift register, operand.
  - Outputs: next accumulator and next shift register.
  - The top level holds the FSM, counter, sign handling and the hi/lo registers.

Test Plan:
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF → done in cycle N+34; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
- MULT, a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV, a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU, a=100, b=7 → lo=14, hi=2.
- DIVU, a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. DIV, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0xDEAD → hi=0xDEAD next cycle, no done. Then MULTU 5×6 with start re-asserted with op=MTLO in cycle N+10 → MTLO ignored; final lo=30, hi=0.
- MULTU 5×6, reset asserted in cycle N+15 → busy=0, done=0, hi=lo=0 next cycle, and no done pulse appears afterwards.
